// File: rtl/wiphase_cpu_v2_debug_ocimem.sv
// -----------------------------------------------------------------------------
// wiphase_cpu_v2_debug_ocimem
//
// Purpose:
//   System-clock side of the CPU on-chip debug memory. This block holds the
//   debug monitor RAM (single port, one 32-bit word per address). It services
//   two kinds of access:
//     - JTAG-host reads and writes. These are driven by the debug slave's
//       `jdo` bus and ocimem action strobes, and bursts can auto-increment
//       the address.
//     - CPU accesses through an Avalon-MM slave port.
//   MonDReg, monitor_ready and monitor_error return to the debug slave's
//   scan-out path.
//
// Ports:
//   clk                      system clock
//   reset_n                  synchronous active-low reset
//   jdo[37:0]                JTAG data
//                              address    = jdo[AW+16:17]
//                              read req   = jdo[34]
//                              autoinc    = jdo[35]
//                              write data = jdo[34:3]
//   take_action_ocimem_a     load address, optionally read
//   take_action_ocimem_b     write jdo data at the current address
//   take_no_action_ocimem_a  read at the current address (burst read)
//   address[AW-1:0]          CPU word address
//   chipselect/read/write    Avalon controls
//   writedata[31:0]          CPU write data
//   byteenable[3:0]          CPU byte lanes
//   debugaccess              CPU writes take effect only while this is high
//   waitrequest              Avalon stall (combinational)
//   readdata[31:0]           CPU read data (registered)
//   MonDReg[31:0]            JTAG data register
//   monitor_ready            last JTAG operation complete
//   monitor_error            sticky error flag
// -----------------------------------------------------------------------------
module wiphase_cpu_v2_debug_ocimem #(
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  input  logic [AW-1:0] address,
  input  logic          chipselect,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  input  logic [3:0]    byteenable,
  input  logic          debugaccess,
  output logic          waitrequest,
  output logic [31:0]   readdata,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JWR,
    ST_CRD,
    ST_CWR
  } state_e;

  // Registered state.
  state_e        state_q;
  logic [AW-1:0] mon_a_q;
  logic [AW-1:0] mon_a_d;
  logic [31:0]   mon_d_q;
  logic [31:0]   readdata_q;
  logic          ready_q;
  logic          error_q;
  logic          ack_q;
  logic          autoinc_q;

  // Monitor RAM and its single shared port.
  logic [31:0]    mem_q [DEPTH];
  logic [AW-1:0]  mem_addr;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]    mem_wdata;
  logic [31:0]    mem_rdata;
  logic [3:0]     mem_be;

  logic jtag_strobe;
  logic cpu_req;
  logic cpu_go;
  logic jtag_in_range;
  logic cpu_in_range;
  logic unused_jdo;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // jdo bits that are not part of any field.
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jtag_strobe   = take_action_ocimem_a | take_action_ocimem_b |
                         take_no_action_ocimem_a;
  assign cpu_req       = chipselect & (read | write);
  assign waitrequest   = cpu_req & ~ack_q;
  // The CPU is served only from IDLE, and only when no JTAG strobe competes.
  assign cpu_go        = (state_q == ST_IDLE) & ~jtag_strobe & cpu_req;
  assign jtag_in_range = in_range(mon_a_q);
  assign cpu_in_range  = in_range(address);
  assign mon_a_d       = autoinc_q ? mon_a_q + 1'b1 : mon_a_q;

  // JTAG and CPU accesses never fall in the same cycle, so a single port is
  // enough. The port is steered by whichever side owns the current cycle.
  always_comb begin
    mem_addr  = mon_a_q;
    mem_wdata = mon_d_q;
    mem_be    = '0;
    if (state_q == ST_JWR) begin
      if (jtag_in_range) mem_be = 4'hF;
    end else if (cpu_go) begin
      mem_addr  = address;
      mem_wdata = writedata;
      if (write && debugaccess && cpu_in_range) mem_be = byteenable;
    end
    // A reset edge cancels any write that would have landed on it.
    if (!reset_n) mem_be = '0;
  end

  assign mem_idx   = mem_addr[IDX_W-1:0];
  assign mem_rdata = in_range(mem_addr) ? mem_q[mem_idx] : '0;

  // NOTE: RAM contents are deliberately left out of reset; adding a reset
  // would stop the array mapping onto a block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // NOTE: reset is sampled synchronously inside the clocked block, and every
  // state register uses non-blocking assignment so all updates land together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      readdata_q <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      ack_q      <= 1'b0;
      autoinc_q  <= 1'b0;
    end else begin
      ack_q <= cpu_go;

      // Strobes outside IDLE are dropped, but the drop is flagged.
      if (jtag_strobe && state_q != ST_IDLE) error_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (take_action_ocimem_a) begin
            mon_a_q   <= jdo[AW+16:17];
            autoinc_q <= jdo[35];
            error_q   <= 1'b0;
            // An address-only load completes at once; a load plus read
            // completes after the JRD cycle.
            ready_q   <= ~jdo[34];
            state_q   <= jdo[34] ? ST_JRD : ST_IDLE;
          end else if (take_no_action_ocimem_a) begin
            ready_q <= 1'b0;
            state_q <= ST_JRD;
          end else if (take_action_ocimem_b) begin
            ready_q <= 1'b0;
            mon_d_q <= jdo[34:3];
            state_q <= ST_JWR;
          end else if (cpu_go) begin
            // When read and write are both asserted, the access is a write.
            if (write) begin
              state_q <= ST_CWR;
            end else begin
              readdata_q <= mem_rdata;
              state_q    <= ST_CRD;
            end
          end
        end

        ST_JRD, ST_JWR: begin
          if (!jtag_in_range) begin
            error_q <= 1'b1;
          end else if (state_q == ST_JRD) begin
            mon_d_q <= mem_rdata;
          end
          // The address advances even when the access was out of range.
          mon_a_q <= mon_a_d;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end

        // CRD/CWR last exactly one cycle: the ack cycle.
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign readdata      = readdata_q;
  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule
